ft245_device_model: RTL and testbench
=====================================

Name: ft245_device_model

Overview:
- Synthesizable device-side model of the FT245 parallel FIFO chip: the peer of the host-side ft245 interface block.
- Responds to the RD#/WR# strobes driven by the interface block and drives RXF#/TXE#/data back.
- Has two internal byte FIFOs with a valid/ready "USB host" side, so the interface block can be looped back on-board or in simulation without the physical chip.
- Also flags protocol violations by the interface block.

Parameters:
- DEPTH, 16, entries per FIFO (power of two, >=2); AW = $clog2(DEPTH)
- RXF_INACTIVE_CYC, 2, cycles RXF# is forced high after each read strobe ends
- TXE_INACTIVE_CYC, 2, cycles TXE# is forced high after each write strobe ends
- RD_MIN_CYC, 3, minimum legal RD# low width in cycles
- WR_MIN_CYC, 3, minimum legal WR# low width in cycles

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous reset, active-high
- rx_data_245  out  8  byte presented to the interface block (device->FPGA)
- rxf_245  out  1  RXF#, low = byte available
- rx_245  in  1  RD#, active low
- tx_data_245  in  8  byte from the interface block
- txe_245  out  1  TXE#, low = space available
- tx_245  in  1  WR#, active low
- tx_oe_245  in  1  interface-block bus-drive enable
- host_rx_data  in  8  byte to queue toward the FPGA
- host_rx_valid  in  1  push request
- host_rx_ready  out  1  = RX FIFO not full (combinational)
- host_tx_data  out  8  head of TX FIFO
- host_tx_valid  out  1  = TX FIFO not empty (combinational)
- host_tx_ready  in  1  pop acknowledge
- rx_level  out  AW+1  RX FIFO occupancy
- tx_level  out  AW+1  TX FIFO occupancy
- err_flags  out  4  sticky: [0] RD while RXF# high, [1] WR while TXE# high, [2] WR fall with tx_oe_245 low, [3] RD/WR pulse shorter than minimum

Behaviour:
- Reset (async, while rst=1):
  - rxf_245=1, txe_245=1, rx_data_245=8'h00.
  - Both FIFOs empty; levels 0; err_flags=0; edge registers = 1 (strobes idle).
  - Host pushes and pops are ignored while rst=1.
  - Reset mid-strobe discards any in-progress transfer; no pop or push occurs.
- Strobe sampling:
  - rd_q and wr_q register rx_245 and tx_245.
  - rd_fall = rd_q & ~rx_245; rd_rise = ~rd_q & rx_245; wr_fall and wr_rise are defined the same way.
- Read path (state RX_IDLE -> RX_ACTIVE -> RX_RECOVER -> RX_IDLE):
  - rd_fall with rxf_245=0: rx_data_245 <= FIFO head (valid 1 cycle after the fall); go to RX_ACTIVE; clear the width counter.
  - rd_fall with rxf_245=1: set err[0]; rx_data_245 <= 8'h00; go to RX_ACTIVE; no pop at the rise.
  - RX_ACTIVE: width counter saturates at RD_MIN_CYC; rxf_245 held low.
  - rd_rise: pop the head (if the strobe was legal); rxf_245 <= 1; load the recover counter with RXF_INACTIVE_CYC; set err[3] if width < RD_MIN_CYC; go to RX_RECOVER.
  - rx_data_245 holds its last value until the next rd_fall.
  - RX_RECOVER: count down; at 0 return to RX_IDLE.
  - RX_IDLE: rxf_245 <= ~(rx_level_next != 0), registered.
  - Push into an empty FIFO produces rxf_245 low 2 cycles after the push handshake.
- Write path (TX_IDLE -> TX_ACTIVE -> TX_RECOVER -> TX_IDLE):
  - wr_fall with txe_245=0: capture tx_data_245 and push to the TX FIFO; set err[2] if tx_oe_245=0 (byte still pushed).
  - wr_fall with txe_245=1: set err[1]; byte dropped.
  - TX_ACTIVE: txe_245 held at its pre-strobe value; width counter as for reads.
  - wr_rise: txe_245 <= 1; load TXE_INACTIVE_CYC; set err[3] if short.
  - TX_IDLE: txe_245 <= (tx_level_next == DEPTH), registered.
- FIFOs:
  - Pointers are AW bits and wrap modulo DEPTH; level is AW+1 bits and ranges 0..DEPTH.
  - A simultaneous push and pop on the same FIFO leaves the level unchanged.
  - Push when full or pop when empty is ignored and is not an error on the host side.
- The RD and WR paths are independent; simultaneous strobes are both serviced.
- Error flags are sticky until reset.

Test Plan:
- Reset sequence, then push 8'hA5 via the host side -> rxf_245 falls 2 cycles later. Drive RD# low for 3 cycles -> rx_data_245=8'hA5 from cycle 1. On RD# rise -> rx_level=0, rxf_245 high and stays high (FIFO empty).
- Push 8'h01,8'h02,8'h03; three RD# pulses of 3 cycles spaced 4 cycles apart -> bytes read back in order. rxf_245 is high for exactly RXF_INACTIVE_CYC=2 cycles after each rise, then low again while bytes remain, and stays high after the last. err_flags=0.
- Loopback: WR# pulses with tx_data_245 = 8'h10..8'h1F and tx_oe_245=1 -> txe_245 high after the 16th pulse (level 16). A 17th WR# -> err[1] set, tx_level stays 16. Host pops all 16 in order.
- Violations: RD# pulse with RXF# high -> err[0], rx_data_245=8'h00, no pop. A 1-cycle WR# pulse -> err[3]. WR# fall with tx_oe_245=0 -> err[2], byte still stored.
- Simultaneous events: host push and RD#-rise pop in the same cycle at level 1 -> level 1. Host pop and WR# fall in the same cycle -> tx_level unchanged.
- Assert rst while RD# is low mid-pulse -> all outputs at reset values immediately. Release rst with RD# high -> no pop, no error.

Source files
------------

// File: rtl/ft245_device_model_if.sv
// rtl/ft245_device_model_if.sv - FT245 parallel FIFO bus between interface block (master) and device (slave).
interface ft245_device_model_if;
  logic [7:0] rx_data_245;
  logic       rxf_245;
  logic       rx_245;
  logic [7:0] tx_data_245;
  logic       txe_245;
  logic       tx_245;
  logic       tx_oe_245;

  modport master (
    input  rx_data_245, rxf_245, txe_245,
    output rx_245, tx_data_245, tx_245, tx_oe_245
  );

  modport slave (
    output rx_data_245, rxf_245, txe_245,
    input  rx_245, tx_data_245, tx_245, tx_oe_245
  );
endinterface

// File: rtl/ft245_device_model.sv
// rtl/ft245_device_model.sv - FT245 device-side model: two byte FIFOs, RD#/WR# servicing, protocol checks.
module ft245_device_model #(
  parameter int DEPTH            = 16,
  parameter int RXF_INACTIVE_CYC = 2,
  parameter int TXE_INACTIVE_CYC = 2,
  parameter int RD_MIN_CYC       = 3,
  parameter int WR_MIN_CYC       = 3,
  localparam int AW              = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  ft245_device_model_if.slave  bus,
  input  logic [7:0]           host_rx_data,
  input  logic                 host_rx_valid,
  output logic                 host_rx_ready,
  output logic [7:0]           host_tx_data,
  output logic                 host_tx_valid,
  input  logic                 host_tx_ready,
  output logic [AW:0]          rx_level,
  output logic [AW:0]          tx_level,
  output logic [3:0]           err_flags
);
  typedef enum logic [1:0] {RX_IDLE, RX_ACTIVE, RX_RECOVER} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_ACTIVE, TX_RECOVER} tx_state_t;

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  rx_state_t      rx_state;
  tx_state_t      tx_state;
  logic           rd_q, wr_q, rd_ok;
  logic           rxf_q, txe_q;
  logic [7:0]     rx_data_q;
  logic [7:0]     rd_wcnt, wr_wcnt, rd_rcnt, wr_rcnt;
  logic [7:0]     rx_mem [DEPTH];
  logic [7:0]     tx_mem [DEPTH];
  logic [AW-1:0]  rx_wptr, rx_rptr, tx_wptr, tx_rptr;
  logic [AW:0]    rx_level_q, tx_level_q;
  logic [3:0]     err_q;
  logic           rd_fall, rd_rise, wr_fall, wr_rise;
  logic           rx_push, rx_pop, tx_push, tx_pop;
  logic           rd_short, wr_short;

  assign rd_fall = rd_q & ~bus.rx_245;
  assign rd_rise = ~rd_q & bus.rx_245;
  assign wr_fall = wr_q & ~bus.tx_245;
  assign wr_rise = ~wr_q & bus.tx_245;

  assign host_rx_ready = (rx_level_q != FULL);
  assign host_tx_valid = (tx_level_q != '0);
  assign host_tx_data  = tx_mem[tx_rptr];

  // A read strobe only pops when it began while RXF# was low.
  assign rx_push  = host_rx_valid & host_rx_ready;
  assign rx_pop   = rd_rise & (rx_state == RX_ACTIVE) & rd_ok & (rx_level_q != '0);
  assign tx_push  = wr_fall & ~txe_q & (tx_state != TX_ACTIVE) & (tx_level_q != FULL);
  assign tx_pop   = host_tx_ready & host_tx_valid;
  assign rd_short = rd_rise & (rx_state == RX_ACTIVE) & (rd_wcnt < 8'(RD_MIN_CYC - 1));
  assign wr_short = wr_rise & (tx_state == TX_ACTIVE) & (wr_wcnt < 8'(WR_MIN_CYC - 1));

  assign bus.rx_data_245 = rx_data_q;
  assign bus.rxf_245     = rxf_q;
  assign bus.txe_245     = txe_q;
  assign rx_level        = rx_level_q;
  assign tx_level        = tx_level_q;
  assign err_flags       = err_q;

  always_ff @(posedge clk) begin
    if (!rst && rx_push) rx_mem[rx_wptr] <= host_rx_data;
    if (!rst && tx_push) tx_mem[tx_wptr] <= bus.tx_data_245;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_wptr <= '0; rx_rptr <= '0; rx_level_q <= '0;
      tx_wptr <= '0; tx_rptr <= '0; tx_level_q <= '0;
      rd_q <= 1'b1; wr_q <= 1'b1;
      err_q <= '0;
    end else begin
      rd_q <= bus.rx_245;
      wr_q <= bus.tx_245;
      if (rx_push) rx_wptr <= rx_wptr + 1'b1;
      if (rx_pop)  rx_rptr <= rx_rptr + 1'b1;
      if (rx_push && !rx_pop)      rx_level_q <= rx_level_q + 1'b1;
      else if (rx_pop && !rx_push) rx_level_q <= rx_level_q - 1'b1;
      if (tx_push) tx_wptr <= tx_wptr + 1'b1;
      if (tx_pop)  tx_rptr <= tx_rptr + 1'b1;
      if (tx_push && !tx_pop)      tx_level_q <= tx_level_q + 1'b1;
      else if (tx_pop && !tx_push) tx_level_q <= tx_level_q - 1'b1;
      err_q <= err_q | {rd_short | wr_short,
                        wr_fall & ~txe_q & ~bus.tx_oe_245,
                        wr_fall & txe_q,
                        rd_fall & rxf_q};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state  <= RX_IDLE;
      rxf_q     <= 1'b1;
      rx_data_q <= 8'h00;
      rd_ok     <= 1'b0;
      rd_wcnt   <= '0;
      rd_rcnt   <= '0;
    end else if (rd_fall) begin
      rx_state  <= RX_ACTIVE;
      rd_ok     <= ~rxf_q;
      rd_wcnt   <= '0;
      rx_data_q <= rxf_q ? 8'h00 : rx_mem[rx_rptr];
    end else begin
      case (rx_state)
        RX_IDLE: rxf_q <= (rx_level_q == '0);
        RX_ACTIVE: begin
          if (rd_rise) begin
            rxf_q    <= 1'b1;
            rd_rcnt  <= 8'(RXF_INACTIVE_CYC);
            rx_state <= RX_RECOVER;
          end else if (rd_wcnt < 8'(RD_MIN_CYC)) begin
            rd_wcnt <= rd_wcnt + 8'd1;
          end
        end
        // Last recovery cycle reloads RXF# so it is high for exactly RXF_INACTIVE_CYC cycles.
        RX_RECOVER: begin
          if (rd_rcnt <= 8'd1) begin
            rx_state <= RX_IDLE;
            rxf_q    <= (rx_level_q == '0);
          end else begin
            rd_rcnt <= rd_rcnt - 8'd1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      txe_q    <= 1'b1;
      wr_wcnt  <= '0;
      wr_rcnt  <= '0;
    end else if (wr_fall) begin
      tx_state <= TX_ACTIVE;
      wr_wcnt  <= '0;
    end else begin
      case (tx_state)
        TX_IDLE: txe_q <= (tx_level_q == FULL);
        TX_ACTIVE: begin
          if (wr_rise) begin
            txe_q    <= 1'b1;
            wr_rcnt  <= 8'(TXE_INACTIVE_CYC);
            tx_state <= TX_RECOVER;
          end else if (wr_wcnt < 8'(WR_MIN_CYC)) begin
            wr_wcnt <= wr_wcnt + 8'd1;
          end
        end
        TX_RECOVER: begin
          if (wr_rcnt <= 8'd1) begin
            tx_state <= TX_IDLE;
            txe_q    <= (tx_level_q == FULL);
          end else begin
            wr_rcnt <= wr_rcnt - 8'd1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ft245_device_model.sv
// tb/tb_ft245_device_model.sv - directed bench for ft245_device_model.
module tb_ft245_device_model;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] host_rx_data = 8'h00;
  logic       host_rx_valid = 1'b0;
  logic       host_rx_ready;
  logic [7:0] host_tx_data;
  logic       host_tx_valid;
  logic       host_tx_ready = 1'b0;
  logic [4:0] rx_level, tx_level;
  logic [3:0] err_flags;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] seen, popped, d;
  logic       rec [0:7];

  always #5 clk = ~clk;

  ft245_device_model_if bus();

  ft245_device_model #(
    .DEPTH(16), .RXF_INACTIVE_CYC(2), .TXE_INACTIVE_CYC(2), .RD_MIN_CYC(3), .WR_MIN_CYC(3)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .host_rx_data(host_rx_data), .host_rx_valid(host_rx_valid), .host_rx_ready(host_rx_ready),
    .host_tx_data(host_tx_data), .host_tx_valid(host_tx_valid), .host_tx_ready(host_tx_ready),
    .rx_level(rx_level), .tx_level(tx_level), .err_flags(err_flags)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic host_push(input logic [7:0] v);
    @(negedge clk);
    host_rx_data  = v;
    host_rx_valid = 1'b1;
    @(negedge clk);
    host_rx_valid = 1'b0;
  endtask

  task automatic host_pop(output logic [7:0] v);
    @(negedge clk);
    v = host_tx_data;
    host_tx_ready = 1'b1;
    @(negedge clk);
    host_tx_ready = 1'b0;
  endtask

  // One RD# (rd=1) or WR# pulse of 'width' cycles followed by 'gap' idle cycles.
  // side: host pop at the WR# fall, or host push of side_d at the RD# rise.
  task automatic strobe(input bit rd, input int width, input int gap, input logic [7:0] wd,
                        input bit oe, input bit side, input logic [7:0] side_d);
    @(negedge clk);
    if (rd) begin
      bus.rx_245 = 1'b0;
    end else begin
      bus.tx_245 = 1'b0;
      bus.tx_data_245 = wd;
      bus.tx_oe_245 = oe;
      if (side) begin
        popped = host_tx_data;
        host_tx_ready = 1'b1;
      end
    end
    for (int i = 0; i < width; i++) begin
      @(negedge clk);
      if (i == 0) begin
        seen = bus.rx_data_245;
        host_tx_ready = 1'b0;
      end
      if (i == width - 1) begin
        if (rd) begin
          bus.rx_245 = 1'b1;
          if (side) begin
            host_rx_data  = side_d;
            host_rx_valid = 1'b1;
          end
        end else begin
          bus.tx_245 = 1'b1;
        end
      end
    end
    for (int j = 0; j < gap; j++) begin
      @(negedge clk);
      host_rx_valid = 1'b0;
      rec[j] = rd ? bus.rxf_245 : bus.txe_245;
    end
  endtask

  initial begin
    bus.rx_245 = 1'b1;
    bus.tx_245 = 1'b1;
    bus.tx_data_245 = 8'h00;
    bus.tx_oe_245 = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_rxf", bus.rxf_245, 1);
    chk("rst_txe", bus.txe_245, 1);
    chk("rst_rxdata", bus.rx_data_245, 8'h00);
    chk("rst_levels", {rx_level, tx_level}, 0);
    chk("rst_err", err_flags, 0);
    chk("rst_hs", {host_rx_ready, host_tx_valid}, 2'b10);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Push latency to RXF# and a single read.
    host_push(8'hA5);
    chk("push_rxf_c1", bus.rxf_245, 1);
    @(negedge clk);
    chk("push_rxf_c2", bus.rxf_245, 0);
    chk("push_level", rx_level, 1);
    strobe(1, 3, 4, 8'h00, 1, 0, 8'h00);
    chk("rd1_data", seen, 8'hA5);
    chk("rd1_level", rx_level, 0);
    chk("rd1_rxf_high", {rec[0], rec[1], rec[2], rec[3]}, 4'b1111);

    // Three queued bytes read in order with RXF# recovery gaps.
    host_push(8'h01);
    host_push(8'h02);
    host_push(8'h03);
    for (int k = 1; k <= 3; k++) begin
      strobe(1, 3, 4, 8'h00, 1, 0, 8'h00);
      chk($sformatf("rd_seq%0d_data", k), seen, k);
      chk($sformatf("rd_seq%0d_rxf", k), {rec[0], rec[1], rec[2]}, (k == 3) ? 3'b111 : 3'b110);
    end
    chk("rd_seq_err", err_flags, 0);

    // Fill the TX FIFO through WR#.
    for (int k = 0; k < 16; k++) strobe(0, 3, 4, 8'h10 + 8'(k), 1, 0, 8'h00);
    chk("wr_full_level", tx_level, 16);
    chk("wr_full_txe", rec[2], 1);
    chk("wr_full_err", err_flags, 0);
    strobe(0, 3, 4, 8'hEE, 1, 0, 8'h00);
    chk("wr_over_err", err_flags, 4'b0010);
    chk("wr_over_level", tx_level, 16);
    for (int k = 0; k < 16; k++) begin
      host_pop(d);
      chk($sformatf("pop%0d", k), d, 8'h10 + 8'(k));
    end
    chk("pop_level", tx_level, 0);

    // Protocol violations.
    strobe(1, 3, 4, 8'h00, 1, 0, 8'h00);
    chk("rd_empty_data", seen, 8'h00);
    chk("rd_empty_err", err_flags, 4'b0011);
    chk("rd_empty_level", rx_level, 0);
    strobe(0, 1, 4, 8'h55, 1, 0, 8'h00);
    chk("wr_short_err", err_flags, 4'b1011);
    chk("wr_short_level", tx_level, 1);
    strobe(0, 3, 4, 8'h66, 0, 0, 8'h00);
    chk("wr_oe_err", err_flags, 4'b1111);
    chk("wr_oe_level", tx_level, 2);
    host_pop(d);
    chk("viol_pop0", d, 8'h55);
    host_pop(d);
    chk("viol_pop1", d, 8'h66);

    // Simultaneous push/pop on each FIFO.
    host_push(8'h77);
    strobe(1, 3, 4, 8'h00, 1, 1, 8'h88);
    chk("sim_rx_data", seen, 8'h77);
    chk("sim_rx_level", rx_level, 1);
    chk("sim_rx_rxf", rec[2], 0);
    strobe(1, 3, 4, 8'h00, 1, 0, 8'h00);
    chk("sim_rx_next", seen, 8'h88);
    strobe(0, 3, 4, 8'h99, 1, 0, 8'h00);
    strobe(0, 3, 4, 8'hAA, 1, 1, 8'h00);
    chk("sim_tx_popped", popped, 8'h99);
    chk("sim_tx_level", tx_level, 1);
    host_pop(d);
    chk("sim_tx_next", d, 8'hAA);

    // Reset in the middle of a read strobe.
    host_push(8'hC3);
    @(negedge clk);
    bus.rx_245 = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_data", bus.rx_data_245, 8'hC3);
    rst = 1'b1;
    #1;
    chk("mid_rst_out", {bus.rxf_245, bus.txe_245, bus.rx_data_245}, {2'b11, 8'h00});
    chk("mid_rst_state", {rx_level, tx_level, err_flags}, 0);
    bus.rx_245 = 1'b1;
    @(negedge clk);
    host_rx_data  = 8'h5A;
    host_rx_valid = 1'b1;
    @(negedge clk);
    host_rx_valid = 1'b0;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("post_rst_err", err_flags, 0);
    chk("post_rst_level", rx_level, 0);
    chk("post_rst_rxf", bus.rxf_245, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
